multi_oneshot: RTL
==================

// Module: multi_oneshot
// PURPOSE
//   Parametrised bank of CHANNELS independent one-shots: 9602-style trigger logic, run-time pulse width per channel.
//   Each channel can be retriggerable or non-retriggerable. Per-channel clear, as on the 9602.
//   Replaces discrete per-timer one-shot instances in board-level timing paths (e.g. serve/score/sound timers).
//   Pulse widths are in CLK cycles.
// PARAMETERS
//   CHANNELS    2              number of independent one-shot channels (>=1)
//   WIDTH       16             width of each channel's period counter; max pulse = 2**WIDTH-1 cycles
//   RETRIG_MASK {CHANNELS{1'b1}}  bit i=1: channel i retriggerable; bit i=0: triggers ignored while active
// PORTS
//   CLK     in   1               system clock, all logic on rising edge
//   RST_N   in   1               asynchronous active-low reset
//   A_N     in   CHANNELS        active-low trigger inputs
//   B       in   CHANNELS        active-high trigger inputs
//   CLR_N   in   CHANNELS        active-low per-channel clear, synchronous
//   PERIOD  in   CHANNELS*WIDTH  pulse length per channel, flattened; ch i = PERIOD[i*WIDTH +: WIDTH]
//   Q       out  CHANNELS        one-shot outputs, active high
//   Q_N     out  CHANNELS        complement of Q
//   DONE    out  CHANNELS        natural-expiry strobe (only with MULTI_ONESHOT_DONE_EN)
// BEHAVIOUR
//   Reset (RST_N=0, async):
//     - all counters 0, Q=0, Q_N=1, DONE=0
//     - prev_trg regs = 1, so a trigger already high at reset release does not fire
//   Trigger condition:
//     - trg[i] = ~A_N[i] | B[i]
//     - fire[i] = trg[i] & ~prev_trg[i] & CLR_N[i]; prev_trg[i] registered every cycle
//   Per channel: states IDLE (cnt==0) and ACTIVE (cnt!=0); Q[i] = (cnt[i]!=0), registered-counter derived.
//   IDLE transitions:
//     - fire & PERIOD!=0 -> cnt<=PERIOD, ACTIVE
//     - fire & PERIOD==0 -> stay IDLE, no pulse
//   ACTIVE transitions, applied in priority order:
//     - CLR_N=0: cnt<=0, IDLE next cycle; no DONE
//     - fire & RETRIG_MASK[i]: cnt<=PERIOD (restart full width); PERIOD==0 here ends pulse, no DONE
//     - otherwise: cnt<=cnt-1; ACTIVE->IDLE when cnt==1
//   Non-retriggerable channel: fire while ACTIVE is ignored, including the last active cycle.
//   Timing and widths:
//     - latency: edge sampled at clock k -> Q=1 from after edge k, for exactly PERIOD cycles if untouched
//     - PERIOD sampled only on the firing cycle; later changes do not affect a running pulse
//     - cnt is unsigned WIDTH bits; never wraps (decrements only while !=0)
//   CLR_N low blocks firing. CLR_N rising edge is not a trigger.
//   A trigger held high fires once; it must fall then rise to fire again.
//   Channels fully independent; simultaneous events on different channels do not interact.
// CONFIGURATION
//   MULTI_ONESHOT_DONE_EN defined:
//     - DONE[i] = 1 for exactly one cycle, the cycle after cnt goes 1->0 by decrement
//     - no DONE on clear, on retrigger with PERIOD=0, or at reset
//   MULTI_ONESHOT_DONE_EN undefined: DONE port and its logic absent. Q/Q_N behaviour identical.
// TESTING
//   T1 reset:
//     - assert RST_N=0 mid-pulse -> Q=0, Q_N=1 immediately (async)
//     - release with B=1 held -> no pulse
//   T2 basic:
//     - ch0 PERIOD=5, B[0] 0->1 at edge k -> Q[0]=1 for cycles k+1..k+5, 0 at k+6
//     - DONE[0]=1 at k+6 only (with _EN)
//   T3 retrigger:
//     - ch0 retrig, PERIOD=5, second rising trigger 3 cycles after first -> Q[0] high 8 cycles total, one DONE
//   T4 non-retrig:
//     - RETRIG_MASK[1]=0, PERIOD=5, retrigger at +3 and at last active cycle -> Q[1] high exactly 5 cycles
//   T5 clear:
//     - CLR_N[0]=0 at cycle +2 of PERIOD=10 pulse -> Q[0]=0 next cycle, no DONE
//     - trigger edge during CLR_N=0 -> ignored
//   T6 edges:
//     - PERIOD=0 trigger -> no pulse
//     - PERIOD=2**WIDTH-1 -> full-length pulse, no wrap
//     - A_N falling edge fires same as B rising
//     - both channels fired same cycle -> independent correct widths

Source files
------------

// File: rtl/multi_oneshot.sv
// multi_oneshot
//   Bank of CHANNELS independent one-shots with 9602-style trigger logic.
//   Each channel fires on a rising edge of trg = ~A_N | B. The pulse width is
//   taken from the channel's PERIOD slice on the firing cycle and counted in CLK
//   cycles. RETRIG_MASK selects retriggerable (1) or non-retriggerable (0)
//   behaviour per channel. CLR_N is a synchronous per-channel clear.
//
//   Optional feature macro: MULTI_ONESHOT_DONE_EN
//     When defined, a DONE output gives a one-cycle strobe after a pulse ends
//     by natural expiry. It does not strobe on clear, on a retrigger with
//     PERIOD=0, or at reset. When undefined, the DONE port and its logic are
//     absent.
//
// Ports
//   CLK     in   1               system clock, rising edge
//   RST_N   in   1               asynchronous active-low reset
//   A_N     in   CHANNELS        active-low trigger inputs
//   B       in   CHANNELS        active-high trigger inputs
//   CLR_N   in   CHANNELS        active-low synchronous clear per channel
//   PERIOD  in   CHANNELS*WIDTH  pulse width per channel, ch i = PERIOD[i*WIDTH +: WIDTH]
//   Q       out  CHANNELS        one-shot outputs, active high
//   Q_N     out  CHANNELS        complement of Q
//   DONE    out  CHANNELS        natural-expiry strobe (MULTI_ONESHOT_DONE_EN only)
module multi_oneshot #(
   parameter int                  CHANNELS    = 2,
   parameter int                  WIDTH       = 16,
   parameter logic [CHANNELS-1:0] RETRIG_MASK = {CHANNELS{1'b1}}
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [CHANNELS-1:0]       A_N,
   input  logic [CHANNELS-1:0]       B,
   input  logic [CHANNELS-1:0]       CLR_N,
   input  logic [CHANNELS*WIDTH-1:0] PERIOD,
   output logic [CHANNELS-1:0]       Q,
   output logic [CHANNELS-1:0]       Q_N
`ifdef MULTI_ONESHOT_DONE_EN
   ,
   output logic [CHANNELS-1:0]       DONE
`endif
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] period_i;
      logic [WIDTH-1:0] cnt_p0;
      logic [WIDTH-1:0] cnt_nxt;
      logic             prev_trg_p0;
      logic             q_p0;
      logic             trg;
      logic             fire;

      assign period_i = PERIOD[i*WIDTH +: WIDTH];
      assign trg      = ~A_N[i] | B[i];
      // CLR_N gates firing, so a clear held across a trigger edge swallows it,
      // and prev_trg keeps tracking so CLR_N release is never seen as an edge.
      assign fire     = trg & ~prev_trg_p0 & CLR_N[i];

      always_comb begin
         cnt_nxt = cnt_p0;
         if (cnt_p0 == '0) begin
            // A zero PERIOD loads zero, i.e. no pulse.
            if (fire) cnt_nxt = period_i;
         end else if (!CLR_N[i]) begin
            cnt_nxt = '0;
         end else if (fire && RETRIG_MASK[i]) begin
            cnt_nxt = period_i;
         end else begin
            // Non-zero here, so the decrement cannot wrap.
            cnt_nxt = cnt_p0 - WIDTH'(1);
         end
      end

`ifdef MULTI_ONESHOT_DONE_EN
      logic done_p0;
      logic natural_end;

      // Only the plain decrement path from 1 counts as a natural expiry.
      assign natural_end = (cnt_p0 == WIDTH'(1)) & CLR_N[i] & ~(fire & RETRIG_MASK[i]);
`endif

      // Stage p0: channel state register
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            cnt_p0      <= '0;
            q_p0        <= 1'b0;
            // Preset high so a trigger already asserted at reset release does not fire.
            prev_trg_p0 <= 1'b1;
`ifdef MULTI_ONESHOT_DONE_EN
            done_p0     <= 1'b0;
`endif
         end else begin
            cnt_p0      <= cnt_nxt;
            q_p0        <= (cnt_nxt != '0);
            prev_trg_p0 <= trg;
`ifdef MULTI_ONESHOT_DONE_EN
            done_p0     <= natural_end;
`endif
         end
      end

      assign Q[i]   = q_p0;
      assign Q_N[i] = ~q_p0;
`ifdef MULTI_ONESHOT_DONE_EN
      assign DONE[i] = done_p0;
`endif
   end

endmodule
